// File: rtl/pbus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single registered PBus with IROM/IRAM decode.
// Optional access timeout is enabled by defining PBUS_ARB_TIMEOUT_EN.
module pbus_arbiter #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [3:0]  IRAM_BASE = 4'h8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        IReq,
  input  logic [14:0] IAddr,
  output logic [15:0] IData,
  output logic        IRdy,
  output logic        IErr,
  input  logic [1:0]  DReq,
  input  logic [14:0] DAddr,
  input  logic [15:0] DWData,
  input  logic [1:0]  DBE,
  output logic [15:0] DRData,
  output logic        DRdy,
  output logic        DErr,
  output logic [14:0] PBusAddr,
  output logic [15:0] PBusData,
  output logic [1:0]  PBusBE,
  output logic [1:0]  PBusReqToIRAM,
  output logic [1:0]  PBusReqToIROM,
  input  logic [15:0] PBusDataIRAM,
  input  logic [15:0] PBusDataIROM,
  input  logic        PBusRdyIRAM,
  input  logic        PBusRdyIROM
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("pbus_arbiter: TIMEOUT must be in 2..255");
  end

  state_t      state;
  logic        master_d;   // 1: data port owns the current access
  logic        last_d;     // 1: data port was served last
  logic        tgt_iram;
  logic        is_read;
  logic        err_flag;

  logic        d_valid;
  logic        grant_d;
  logic        is_irom;
  logic        is_iram;
  logic        bad_access;
  logic        tgt_rdy;
  logic [14:0] sel_addr;
  logic [1:0]  sel_code;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be;
  logic [15:0] tgt_data;

  // Reserved code 11 counts as idle; on a tie the port not served last wins.
  assign d_valid   = (DReq == 2'b01) || (DReq == 2'b10);
  assign grant_d   = d_valid && (!IReq || !last_d);
  assign sel_addr  = grant_d ? DAddr  : IAddr;
  assign sel_code  = grant_d ? DReq   : 2'b01;
  assign sel_wdata = grant_d ? DWData : 16'h0000;
  assign sel_be    = grant_d ? DBE    : 2'b11;

  // Word address bit [14] is byte address bit [15].
  assign is_irom    = (sel_addr[14:10] == 5'd0);
  assign is_iram    = (sel_addr[14:11] == IRAM_BASE);
  assign bad_access = !(is_irom || is_iram) || (is_irom && sel_code == 2'b10);

  assign tgt_rdy  = tgt_iram ? PBusRdyIRAM  : PBusRdyIROM;
  assign tgt_data = tgt_iram ? PBusDataIRAM : PBusDataIROM;

`ifdef PBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] busy_cnt;
`endif

  // NOTE: async reset clears every register including the read-data holding
  // registers, so an access interrupted by reset leaves nothing to pulse.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      master_d      <= 1'b0;
      last_d        <= 1'b0;
      tgt_iram      <= 1'b0;
      is_read       <= 1'b0;
      err_flag      <= 1'b0;
      IData         <= '0;
      IRdy          <= 1'b0;
      IErr          <= 1'b0;
      DRData        <= '0;
      DRdy          <= 1'b0;
      DErr          <= 1'b0;
      PBusAddr      <= '0;
      PBusData      <= '0;
      PBusBE        <= '0;
      PBusReqToIRAM <= '0;
      PBusReqToIROM <= '0;
`ifdef PBUS_ARB_TIMEOUT_EN
      busy_cnt      <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; the pulse defaults below are overridden
      // by later assignments in the same edge without ordering hazards.
      IRdy <= 1'b0;
      IErr <= 1'b0;
      DRdy <= 1'b0;
      DErr <= 1'b0;
      case (state)
        IDLE: begin
          if (IReq || d_valid) begin
            master_d <= grant_d;
            PBusAddr <= sel_addr;
            PBusData <= sel_wdata;
            PBusBE   <= sel_be;
            tgt_iram <= is_iram;
            is_read  <= (sel_code == 2'b01);
`ifdef PBUS_ARB_TIMEOUT_EN
            busy_cnt <= '0;
`endif
            if (bad_access) begin
              err_flag <= 1'b1;
              state    <= RESP;
            end else begin
              err_flag <= 1'b0;
              if (is_iram) PBusReqToIRAM <= sel_code;
              else         PBusReqToIROM <= sel_code;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (tgt_rdy) begin
            PBusReqToIRAM <= '0;
            PBusReqToIROM <= '0;
            if (is_read) begin
              if (master_d) DRData <= tgt_data;
              else          IData  <= tgt_data;
            end
            state <= RESP;
          end
`ifdef PBUS_ARB_TIMEOUT_EN
          else if (busy_cnt == TIMEOUT_LAST) begin
            PBusReqToIRAM <= '0;
            PBusReqToIROM <= '0;
            err_flag      <= 1'b1;
            state         <= RESP;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (master_d) begin
            DRdy <= !err_flag;
            DErr <= err_flag;
          end else begin
            IRdy <= !err_flag;
            IErr <= err_flag;
          end
          last_d <= master_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_arbiter.sv
// Scoreboard bench for pbus_arbiter: stimulus pushes expected bus/response
// entries, independent monitors pop and compare when the DUT presents them.
module tb_pbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        IReq = 1'b0;
  logic [14:0] IAddr = '0;
  logic [15:0] IData;
  logic        IRdy, IErr;
  logic [1:0]  DReq = 2'b00;
  logic [14:0] DAddr = '0;
  logic [15:0] DWData = '0;
  logic [1:0]  DBE = 2'b00;
  logic [15:0] DRData;
  logic        DRdy, DErr;
  logic [14:0] PBusAddr;
  logic [15:0] PBusData;
  logic [1:0]  PBusBE;
  logic [1:0]  PBusReqToIRAM, PBusReqToIROM;
  logic [15:0] iram_data = '0, irom_data = '0;
  logic        iram_rdy_model = 1'b0, irom_rdy_model = 1'b0, iram_rdy_force = 1'b0;
  logic        PBusRdyIRAM, PBusRdyIROM;

  assign PBusRdyIRAM = iram_rdy_model | iram_rdy_force;
  assign PBusRdyIROM = irom_rdy_model;

  pbus_arbiter dut (
    .clk(clk), .rst_l(rst_l),
    .IReq(IReq), .IAddr(IAddr), .IData(IData), .IRdy(IRdy), .IErr(IErr),
    .DReq(DReq), .DAddr(DAddr), .DWData(DWData), .DBE(DBE),
    .DRData(DRData), .DRdy(DRdy), .DErr(DErr),
    .PBusAddr(PBusAddr), .PBusData(PBusData), .PBusBE(PBusBE),
    .PBusReqToIRAM(PBusReqToIRAM), .PBusReqToIROM(PBusReqToIROM),
    .PBusDataIRAM(iram_data), .PBusDataIROM(irom_data),
    .PBusRdyIRAM(PBusRdyIRAM), .PBusRdyIROM(PBusRdyIROM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          iram;
    logic [1:0]  code;
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    int          dur;   // -1: access is cut short, duration not checked
  } bus_exp_t;

  typedef struct {
    bit          dport;
    bit          err;
    logic [15:0] data;
    int          at;    // absolute cycle of the pulse
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  task automatic exp_bus(input bit iram, input logic [1:0] code, input logic [14:0] addr,
                         input logic [15:0] data, input logic [1:0] be, input int dur);
    bus_exp_t e;
    e.iram = iram; e.code = code; e.addr = addr; e.data = data; e.be = be; e.dur = dur;
    bus_q.push_back(e);
  endtask

  task automatic exp_resp(input bit dport, input bit err, input logic [15:0] data, input int lat);
    resp_exp_t e;
    e.dport = dport; e.err = err; e.data = data; e.at = cyc + lat;
    resp_q.push_back(e);
  endtask

  // Target model: ready after 'delay' BUSY cycles of a continuous request.
  int irom_delay = 0, iram_delay = 0, irom_cnt = 0, iram_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (PBusReqToIROM != 2'b00) begin
      irom_rdy_model = (irom_cnt >= irom_delay);
      irom_cnt++;
    end else begin
      irom_rdy_model = 1'b0;
      irom_cnt = 0;
    end
    if (PBusReqToIRAM != 2'b00) begin
      iram_rdy_model = (iram_cnt >= iram_delay);
      iram_cnt++;
    end else begin
      iram_rdy_model = 1'b0;
      iram_cnt = 0;
    end
  end

  // Bus monitor: compares each PBus access on its first cycle, then stability and duration.
  initial begin
    bus_exp_t    cur;
    bit          prev = 1'b0;
    int          dur = 0;
    forever begin
      bit         act, act_iram;
      logic [1:0] act_code;
      @(negedge clk);
      act      = (PBusReqToIRAM != 2'b00) || (PBusReqToIROM != 2'b00);
      act_iram = (PBusReqToIRAM != 2'b00);
      act_code = act_iram ? PBusReqToIRAM : PBusReqToIROM;
      if (act && !prev) begin
        check(!(PBusReqToIRAM != 2'b00 && PBusReqToIROM != 2'b00), "bus_one_target",
              {PBusReqToIRAM, PBusReqToIROM}, 0);
        if (bus_q.size() == 0) begin
          check(1'b0, "bus_unexpected", {act_iram, act_code, PBusAddr}, 0);
          cur.dur = -1; cur.iram = act_iram; cur.code = act_code;
          cur.addr = PBusAddr; cur.data = PBusData; cur.be = PBusBE;
        end else begin
          cur = bus_q.pop_front();
          check(act_iram == cur.iram, "bus_target", act_iram, cur.iram);
          check(act_code == cur.code, "bus_code", act_code, cur.code);
          check(PBusAddr == cur.addr, "bus_addr", PBusAddr, cur.addr);
          check(PBusData == cur.data, "bus_data", PBusData, cur.data);
          check(PBusBE == cur.be, "bus_be", PBusBE, cur.be);
        end
        dur = 1;
      end else if (act && prev) begin
        dur++;
        check({act_iram, act_code, PBusAddr, PBusData, PBusBE} ==
              {cur.iram, cur.code, cur.addr, cur.data, cur.be}, "bus_stable",
              {act_iram, act_code, PBusAddr, PBusData, PBusBE},
              {cur.iram, cur.code, cur.addr, cur.data, cur.be});
      end else if (!act && prev) begin
        if (cur.dur >= 0) check(dur == cur.dur, "bus_duration", dur, cur.dur);
      end
      prev = act;
    end
  end

  // Response monitor: every Rdy/Err pulse must match the head of the queue.
  initial forever begin
    logic [3:0]  pulses;
    resp_exp_t   e;
    bit          dport, err;
    logic [15:0] data;
    @(negedge clk);
    pulses = {IRdy, IErr, DRdy, DErr};
    if (pulses != 4'b0000) begin
      dport = DRdy | DErr;
      err   = IErr | DErr;
      data  = dport ? DRData : IData;
      check($countones(pulses) == 1, "resp_onehot", pulses, 0);
      if (resp_q.size() == 0) begin
        check(1'b0, "resp_unexpected", pulses, 0);
      end else begin
        e = resp_q.pop_front();
        check(dport == e.dport, "resp_port", dport, e.dport);
        check(err == e.err, "resp_err", err, e.err);
        check(data == e.data, "resp_data", data, e.data);
        check(cyc == e.at, "resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_pulse(input bit dport, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dport ? (DRdy | DErr) : (IRdy | IErr)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(1'b0, name, 0, 1);
  endtask

  task automatic drive_fetch(input logic [14:0] addr);
    IAddr = addr;
    IReq  = 1'b1;
    wait_pulse(1'b0, "fetch_wait");
    IReq  = 1'b0;
  endtask

  task automatic drive_data(input logic [1:0] code, input logic [14:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be);
    DAddr  = addr;
    DWData = wdata;
    DBE    = be;
    DReq   = code;
    wait_pulse(1'b1, "data_wait");
    DReq   = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    check(IData == 0, {tag, "_idata"}, IData, 0);
    check(DRData == 0, {tag, "_drdata"}, DRData, 0);
    check({IRdy, IErr, DRdy, DErr} == 0, {tag, "_pulses"}, {IRdy, IErr, DRdy, DErr}, 0);
    check(PBusAddr == 0, {tag, "_pbus_addr"}, PBusAddr, 0);
    check(PBusData == 0, {tag, "_pbus_data"}, PBusData, 0);
    check(PBusBE == 0, {tag, "_pbus_be"}, PBusBE, 0);
    check({PBusReqToIRAM, PBusReqToIROM} == 0, {tag, "_pbus_req"},
          {PBusReqToIRAM, PBusReqToIROM}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Fetch from IROM, ready in first BUSY cycle.
    @(negedge clk);
    irom_data = 16'hBEEF;
    exp_bus(1'b0, 2'b01, 15'h0010, 16'h0000, 2'b11, 1);
    exp_resp(1'b0, 1'b0, 16'hBEEF, 3);
    drive_fetch(15'h0010);

    // Tie: last served is fetch, so the data write to IRAM goes first.
    @(negedge clk);
    irom_data = 16'h1234;
    exp_bus(1'b1, 2'b10, 15'h4000, 16'hA55A, 2'b10, 1);
    exp_bus(1'b0, 2'b01, 15'h0020, 16'h0000, 2'b11, 1);
    exp_resp(1'b1, 1'b0, 16'h0000, 3);
    exp_resp(1'b0, 1'b0, 16'h1234, 6);
    fork
      drive_data(2'b10, 15'h4000, 16'hA55A, 2'b10);
      drive_fetch(15'h0020);
    join

    // Write to IROM: no bus access, error.
    @(negedge clk);
    exp_resp(1'b1, 1'b1, 16'h0000, 2);
    drive_data(2'b10, 15'h0005, 16'h1111, 2'b11);

    // IRAM read, then unmapped read leaves DRData unchanged.
    @(negedge clk);
    iram_data = 16'hC0DE;
    exp_bus(1'b1, 2'b01, 15'h4001, 16'h0000, 2'b11, 1);
    exp_resp(1'b1, 1'b0, 16'hC0DE, 3);
    drive_data(2'b01, 15'h4001, 16'h0000, 2'b11);
    @(negedge clk);
    exp_resp(1'b1, 1'b1, 16'hC0DE, 2);
    drive_data(2'b01, 15'h2000, 16'h0000, 2'b11);

    // Tie again: data was served last, so fetch goes first.
    @(negedge clk);
    irom_data = 16'h5678;
    iram_data = 16'h0F0F;
    exp_bus(1'b0, 2'b01, 15'h0030, 16'h0000, 2'b11, 1);
    exp_bus(1'b1, 2'b01, 15'h4002, 16'h0000, 2'b01, 1);
    exp_resp(1'b0, 1'b0, 16'h5678, 3);
    exp_resp(1'b1, 1'b0, 16'h0F0F, 6);
    fork
      drive_data(2'b01, 15'h4002, 16'h0000, 2'b01);
      drive_fetch(15'h0030);
    join

    // Slow IROM with a stray IRAM ready that must be ignored.
    @(negedge clk);
    irom_delay     = 3;
    iram_rdy_force = 1'b1;
    irom_data      = 16'h9999;
    exp_bus(1'b0, 2'b01, 15'h0040, 16'h0000, 2'b11, 4);
    exp_resp(1'b0, 1'b0, 16'h9999, 6);
    drive_fetch(15'h0040);
    iram_rdy_force = 1'b0;
    irom_delay     = 0;

    // Reserved data code is idle.
    @(negedge clk);
    DAddr = 15'h4000;
    DReq  = 2'b11;
    repeat (3) @(negedge clk);
    check({PBusReqToIRAM, PBusReqToIROM} == 0, "reserved_idle",
          {PBusReqToIRAM, PBusReqToIROM}, 0);
    DReq = 2'b00;

    // IRAM never ready.
    @(negedge clk);
    iram_delay = 100000;
`ifdef PBUS_ARB_TIMEOUT_EN
    exp_bus(1'b1, 2'b01, 15'h4003, 16'h0000, 2'b11, 15);
    exp_resp(1'b1, 1'b1, 16'h0F0F, 17);
    drive_data(2'b01, 15'h4003, 16'h0000, 2'b11);
    @(negedge clk);
    exp_bus(1'b1, 2'b01, 15'h4004, 16'h0000, 2'b11, -1);
    DAddr  = 15'h4004;
    DWData = 16'h0000;
    DBE    = 2'b11;
    DReq   = 2'b01;
    repeat (5) @(negedge clk);
`else
    exp_bus(1'b1, 2'b01, 15'h4003, 16'h0000, 2'b11, -1);
    DAddr  = 15'h4003;
    DWData = 16'h0000;
    DBE    = 2'b11;
    DReq   = 2'b01;
    repeat (100) @(negedge clk);
    check(PBusReqToIRAM == 2'b01, "busy_persist", PBusReqToIRAM, 2'b01);
`endif

    // Asynchronous reset in the middle of BUSY.
    #2 rst_l = 1'b0;
    #1 check_all_zero("busy_reset");
    DReq = 2'b00;
    iram_delay = 0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // Normal service after reset.
    @(negedge clk);
    irom_data = 16'h0ABC;
    exp_bus(1'b0, 2'b01, 15'h0050, 16'h0000, 2'b11, 1);
    exp_resp(1'b0, 1'b0, 16'h0ABC, 3);
    drive_fetch(15'h0050);

    repeat (4) @(negedge clk);
    check(resp_q.size() == 0, "resp_queue_drained", resp_q.size(), 0);
    check(bus_q.size() == 0, "bus_queue_drained", bus_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
